// File: rtl/id_ex_pipe_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op classes, the control bundle
// carried from ID to EX, and the all-zero bubble.
package id_ex_pipe_stage_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } aluOp_e;

    localparam int unsigned CTRL_W = 7;

    typedef struct packed {
        logic   regWrite;
        logic   memToReg;
        logic   memRead;
        logic   memWrite;
        logic   aluSrc;
        aluOp_e aluOp;
    } ctrl_t;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_stage_load_use_detect.sv
// Load-use hazard detector: the load in EX targets a register the ID
// instruction reads. x0 never hazards.
module load_use_detect #(
    parameter int unsigned RW = 5
) (
    input  logic          ex_MemRead,
    input  logic [RW-1:0] ex_rd,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    output logic          hazard
);

    // rs2 is compared even for I-type; the occasional spurious stall is accepted.
    assign hazard = ex_MemRead && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with load-use bubble insertion, cache-stall freeze
// and a saturating count of inserted bubbles.
module id_ex_pipe_stage
    import id_ex_pipe_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RW   = 5,
    parameter int unsigned CW   = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_stall_i,
    input  logic            id_RegWrite_i,
    input  logic            id_MemtoReg_i,
    input  logic            id_MemRead_i,
    input  logic            id_MemWrite_i,
    input  logic            id_ALUSrc_i,
    input  logic [1:0]      id_ALUOp_i,
    input  logic [XLEN-1:0] id_rs1data_i,
    input  logic [XLEN-1:0] id_rs2data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [9:0]      id_funct_i,
    input  logic [RW-1:0]   id_rs1_i,
    input  logic [RW-1:0]   id_rs2_i,
    input  logic [RW-1:0]   id_rd_i,
    output logic            ex_RegWrite_o,
    output logic            ex_MemtoReg_o,
    output logic            ex_MemRead_o,
    output logic            ex_MemWrite_o,
    output logic            ex_ALUSrc_o,
    output logic [1:0]      ex_ALUOp_o,
    output logic [XLEN-1:0] ex_rs1data_o,
    output logic [XLEN-1:0] ex_rs2data_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [9:0]      ex_funct_o,
    output logic [RW-1:0]   ex_rs1_o,
    output logic [RW-1:0]   ex_rs2_o,
    output logic [RW-1:0]   ex_rd_o,
    output logic            PCWrite_o,
    output logic            IFIDWrite_o,
    output logic            NoOp_o,
    output logic [CW-1:0]   stall_cnt_o
);

    ctrl_t idCtrl;
    ctrl_t exCtrl;
    logic  hazard;

    assign idCtrl = '{
        regWrite: id_RegWrite_i,
        memToReg: id_MemtoReg_i,
        memRead:  id_MemRead_i,
        memWrite: id_MemWrite_i,
        aluSrc:   id_ALUSrc_i,
        aluOp:    aluOp_e'(id_ALUOp_i)
    };

    load_use_detect #(.RW(RW)) uLoadUse (
        .ex_MemRead (exCtrl.memRead),
        .ex_rd      (ex_rd_o),
        .id_rs1     (id_rs1_i),
        .id_rs2     (id_rs2_i),
        .hazard     (hazard)
    );

    // A cache stall takes precedence: the hazard stays pending and is
    // bubbled once the stall clears.
    assign PCWrite_o   = ~(hazard | mem_stall_i);
    assign IFIDWrite_o = ~(hazard | mem_stall_i);
    assign NoOp_o      = hazard & ~mem_stall_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exCtrl       <= ctrl_t'(CTRL_BUBBLE);
            ex_rs1data_o <= '0;
            ex_rs2data_o <= '0;
            ex_imm_o     <= '0;
            ex_funct_o   <= '0;
            ex_rs1_o     <= '0;
            ex_rs2_o     <= '0;
            ex_rd_o      <= '0;
            stall_cnt_o  <= '0;
        end else if (!mem_stall_i) begin
            ex_rs1data_o <= id_rs1data_i;
            ex_rs2data_o <= id_rs2data_i;
            ex_imm_o     <= id_imm_i;
            ex_funct_o   <= id_funct_i;
            ex_rs1_o     <= id_rs1_i;
            ex_rs2_o     <= id_rs2_i;
            ex_rd_o      <= id_rd_i;
            if (hazard) begin
                exCtrl <= ctrl_t'(CTRL_BUBBLE);
                if (stall_cnt_o != '1)
                    stall_cnt_o <= stall_cnt_o + CW'(1);
            end else begin
                exCtrl <= idCtrl;
            end
        end
    end

    assign ex_RegWrite_o = exCtrl.regWrite;
    assign ex_MemtoReg_o = exCtrl.memToReg;
    assign ex_MemRead_o  = exCtrl.memRead;
    assign ex_MemWrite_o = exCtrl.memWrite;
    assign ex_ALUSrc_o   = exCtrl.aluSrc;
    assign ex_ALUOp_o    = exCtrl.aluOp;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage against a behavioural model of the
// EX-side state and bubble counter.
module tb_id_ex_pipe_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned CW   = 4;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_stall;
    logic            idRegWrite, idMemtoReg, idMemRead, idMemWrite, idALUSrc;
    logic [1:0]      idALUOp;
    logic [XLEN-1:0] idRs1data, idRs2data, idImm;
    logic [9:0]      idFunct;
    logic [RW-1:0]   idRs1, idRs2, idRd;

    logic            ex_RegWrite_o, ex_MemtoReg_o, ex_MemRead_o, ex_MemWrite_o, ex_ALUSrc_o;
    logic [1:0]      ex_ALUOp_o;
    logic [XLEN-1:0] ex_rs1data_o, ex_rs2data_o, ex_imm_o;
    logic [9:0]      ex_funct_o;
    logic [RW-1:0]   ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic            PCWrite_o, IFIDWrite_o, NoOp_o;
    logic [CW-1:0]   stall_cnt_o;

    int errors = 0;
    int checks = 0;

    // Model: what EX should hold, and how many bubbles have been inserted.
    typedef struct {
        logic            rw, mtr, mr, mw, as;
        logic [1:0]      op;
        logic [XLEN-1:0] d1, d2, imm;
        logic [9:0]      fn;
        logic [RW-1:0]   rs1, rs2, rd;
    } exState_t;

    exState_t    mEx;
    int unsigned mCnt;

    always #5 clk = ~clk;

    id_ex_pipe_stage #(.XLEN(XLEN), .RW(RW), .CW(CW)) dut (
        .clk_i(clk), .rst_i(rst), .mem_stall_i(mem_stall),
        .id_RegWrite_i(idRegWrite), .id_MemtoReg_i(idMemtoReg), .id_MemRead_i(idMemRead),
        .id_MemWrite_i(idMemWrite), .id_ALUSrc_i(idALUSrc), .id_ALUOp_i(idALUOp),
        .id_rs1data_i(idRs1data), .id_rs2data_i(idRs2data), .id_imm_i(idImm),
        .id_funct_i(idFunct), .id_rs1_i(idRs1), .id_rs2_i(idRs2), .id_rd_i(idRd),
        .ex_RegWrite_o(ex_RegWrite_o), .ex_MemtoReg_o(ex_MemtoReg_o), .ex_MemRead_o(ex_MemRead_o),
        .ex_MemWrite_o(ex_MemWrite_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_ALUOp_o(ex_ALUOp_o),
        .ex_rs1data_o(ex_rs1data_o), .ex_rs2data_o(ex_rs2data_o), .ex_imm_o(ex_imm_o),
        .ex_funct_o(ex_funct_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
        .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .NoOp_o(NoOp_o),
        .stall_cnt_o(stall_cnt_o)
    );

    function automatic logic [127:0] dutVec();
        return {ex_RegWrite_o, ex_MemtoReg_o, ex_MemRead_o, ex_MemWrite_o, ex_ALUSrc_o,
                ex_ALUOp_o, ex_rs1data_o, ex_rs2data_o, ex_imm_o, ex_funct_o,
                ex_rs1_o, ex_rs2_o, ex_rd_o};
    endfunction

    function automatic logic [127:0] expVec();
        return {mEx.rw, mEx.mtr, mEx.mr, mEx.mw, mEx.as, mEx.op, mEx.d1, mEx.d2,
                mEx.imm, mEx.fn, mEx.rs1, mEx.rs2, mEx.rd};
    endfunction

    function automatic bit mHazard();
        return mEx.mr && (mEx.rd != 0) && (mEx.rd == idRs1 || mEx.rd == idRs2);
    endfunction

    task automatic modelReset();
        mEx  = '{default: '0};
        mCnt = 0;
    endtask

    task automatic clearId();
        {idRegWrite, idMemtoReg, idMemRead, idMemWrite, idALUSrc} = '0;
        idALUOp = '0; idRs1data = '0; idRs2data = '0; idImm = '0; idFunct = '0;
        idRs1 = '0; idRs2 = '0; idRd = '0;
    endtask

    task automatic randId();
        idRegWrite = 1'($urandom); idMemtoReg = 1'($urandom); idMemRead = 1'($urandom);
        idMemWrite = 1'($urandom); idALUSrc = 1'($urandom); idALUOp = 2'($urandom);
        idRs1data = $urandom; idRs2data = $urandom; idImm = $urandom; idFunct = 10'($urandom);
        idRs1 = RW'($urandom_range(0, 3)); idRs2 = RW'($urandom_range(0, 3));
        idRd = RW'($urandom_range(0, 3));
    endtask

    // Advance one clock; the model takes the stage's rules at face value.
    task automatic tick();
        exState_t nxt;
        int unsigned nCnt;
        nxt  = mEx;
        nCnt = mCnt;
        if (!mem_stall) begin
            nxt = '{rw: idRegWrite, mtr: idMemtoReg, mr: idMemRead, mw: idMemWrite,
                    as: idALUSrc, op: idALUOp, d1: idRs1data, d2: idRs2data, imm: idImm,
                    fn: idFunct, rs1: idRs1, rs2: idRs2, rd: idRd};
            if (mHazard()) begin
                {nxt.rw, nxt.mtr, nxt.mr, nxt.mw, nxt.as} = '0;
                nxt.op = '0;
                nCnt = (mCnt == MAXC) ? MAXC : mCnt + 1;
            end
        end
        @(posedge clk);
        #1;
        mEx  = nxt;
        mCnt = nCnt;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_stall = 1'b0; clearId(); modelReset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dutVec() !== '0) begin errors++; $display("FAIL reset_ex: got %h want 0", dutVec()); end
        checks++;
        if (stall_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o); end
        checks++;
        if ({PCWrite_o, IFIDWrite_o, NoOp_o} !== 3'b110) begin
            errors++; $display("FAIL reset_comb: got %b want 110", {PCWrite_o, IFIDWrite_o, NoOp_o});
        end
        rst = 1'b0;
        #2;
    endtask

    task automatic test_passthrough();
        clearId();
        idRd = 5; idRegWrite = 1'b1; idRs1data = 32'h1234;
        #1;
        checks++;
        if (PCWrite_o !== 1'b1) begin errors++; $display("FAIL pass_pcw: got %b want 1", PCWrite_o); end
        tick();
        checks++;
        if ({ex_rd_o, ex_RegWrite_o, ex_rs1data_o} !== {5'd5, 1'b1, 32'h1234}) begin
            errors++; $display("FAIL pass_fields: rd=%0d rw=%b d1=%h want 5 1 1234",
                               ex_rd_o, ex_RegWrite_o, ex_rs1data_o);
        end
        checks++;
        if (dutVec() !== expVec()) begin errors++; $display("FAIL pass_all: got %h want %h", dutVec(), expVec()); end
    endtask

    task automatic test_load_use();
        clearId();
        idMemRead = 1'b1; idRegWrite = 1'b1; idMemtoReg = 1'b1; idRd = 7; idRs1 = 2;
        tick();
        clearId();
        idRegWrite = 1'b1; idALUSrc = 1'b1; idALUOp = 2'b10; idRs1 = 3; idRs2 = 7; idRd = 8;
        #1;
        checks++;
        if ({PCWrite_o, IFIDWrite_o, NoOp_o} !== 3'b001) begin
            errors++; $display("FAIL lu_comb: got %b want 001", {PCWrite_o, IFIDWrite_o, NoOp_o});
        end
        tick();
        checks++;
        if ({ex_RegWrite_o, ex_MemtoReg_o, ex_MemRead_o, ex_MemWrite_o, ex_ALUSrc_o, ex_ALUOp_o} !== 7'd0) begin
            errors++; $display("FAIL lu_bubble: ctrl=%b want 0",
                {ex_RegWrite_o, ex_MemtoReg_o, ex_MemRead_o, ex_MemWrite_o, ex_ALUSrc_o, ex_ALUOp_o});
        end
        checks++;
        if (stall_cnt_o !== 4'd1) begin errors++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt_o); end
        checks++;
        if (PCWrite_o !== 1'b1) begin errors++; $display("FAIL lu_release: pcw=%b want 1", PCWrite_o); end
        checks++;
        if (dutVec() !== expVec()) begin errors++; $display("FAIL lu_all: got %h want %h", dutVec(), expVec()); end
    endtask

    task automatic test_x0();
        clearId();
        idMemRead = 1'b1; idRd = 0; idRs1 = 4;
        tick();
        clearId();
        idRs1 = 0; idRs2 = 0;
        #1;
        checks++;
        if ({PCWrite_o, NoOp_o} !== 2'b10) begin
            errors++; $display("FAIL x0_comb: got %b want 10", {PCWrite_o, NoOp_o});
        end
        tick();
        checks++;
        if (stall_cnt_o !== CW'(mCnt)) begin errors++; $display("FAIL x0_cnt: got %0d want %0d", stall_cnt_o, mCnt); end
    endtask

    task automatic test_cache_stall();
        logic [127:0] frozen;
        int unsigned  cnt0;
        clearId();
        idMemRead = 1'b1; idRegWrite = 1'b1; idRd = 9; idRs1 = 1;
        tick();
        frozen = expVec();
        cnt0   = mCnt;
        for (int i = 0; i < 3; i++) begin
            randId();
            idRs1 = 9;
            mem_stall = 1'b1;
            #1;
            checks++;
            if ({PCWrite_o, IFIDWrite_o, NoOp_o} !== 3'b000) begin
                errors++; $display("FAIL stall_comb[%0d]: got %b want 000", i, {PCWrite_o, IFIDWrite_o, NoOp_o});
            end
            tick();
            checks++;
            if (dutVec() !== frozen || stall_cnt_o !== CW'(cnt0)) begin
                errors++; $display("FAIL stall_hold[%0d]: got %h/%0d want %h/%0d", i, dutVec(), stall_cnt_o, frozen, cnt0);
            end
        end
        mem_stall = 1'b0;
        #1;
        checks++;
        if (NoOp_o !== 1'b1) begin errors++; $display("FAIL stall_bubble: noop=%b want 1", NoOp_o); end
        tick();
        checks++;
        if (stall_cnt_o !== CW'(cnt0 + 1) || ex_MemRead_o !== 1'b0) begin
            errors++; $display("FAIL stall_after: cnt=%0d mr=%b want %0d 0", stall_cnt_o, ex_MemRead_o, cnt0 + 1);
        end
        checks++;
        if (NoOp_o !== 1'b0) begin errors++; $display("FAIL stall_single: noop=%b want 0", NoOp_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            randId();
            mem_stall = ($urandom_range(0, 4) == 0);
            #1;
            checks++;
            if ({PCWrite_o, IFIDWrite_o, NoOp_o} !==
                {~(mHazard() | mem_stall), ~(mHazard() | mem_stall), mHazard() & ~mem_stall}) begin
                errors++; $display("FAIL rand_comb[%0d]: got %b haz=%b stall=%b", i,
                                   {PCWrite_o, IFIDWrite_o, NoOp_o}, mHazard(), mem_stall);
            end
            tick();
            checks++;
            if (dutVec() !== expVec() || stall_cnt_o !== CW'(mCnt)) begin
                errors++; $display("FAIL rand_state[%0d]: got %h/%0d want %h/%0d", i,
                                   dutVec(), stall_cnt_o, expVec(), mCnt);
            end
        end
        mem_stall = 1'b0;
    endtask

    task automatic test_async_reset();
        clearId();
        idMemRead = 1'b1; idRd = 3; idImm = 32'hdead_beef; idRs1 = 1; idRs2 = 1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (dutVec() !== '0 || stall_cnt_o !== '0) begin
            errors++; $display("FAIL async_rst: got %h/%0d want 0/0", dutVec(), stall_cnt_o);
        end
        #1;
        rst = 1'b0;
        modelReset();
        randId();
        tick();
        checks++;
        if (dutVec() !== expVec()) begin errors++; $display("FAIL async_capture: got %h want %h", dutVec(), expVec()); end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        modelReset();
        clearId();
        tick();
        for (int k = 0; k < 16; k++) begin
            clearId();
            idMemRead = 1'b1; idRd = RW'(k % 31 + 1);
            tick();
            clearId();
            idRs1 = RW'(k % 31 + 1);
            #1;
            checks++;
            if (NoOp_o !== 1'b1) begin errors++; $display("FAIL sat_haz[%0d]: noop=%b want 1", k, NoOp_o); end
            tick();
            checks++;
            if (stall_cnt_o !== CW'(mCnt)) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, stall_cnt_o, mCnt); end
        end
        checks++;
        if (stall_cnt_o !== 4'd15) begin errors++; $display("FAIL sat_final: got %0d want 15", stall_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_use();
        test_x0();
        test_cache_stall();
        test_random();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
